// File: rtl/nco_word_loader_pkg.sv
// Shared NCO definitions: control word layout and loader state encoding.
// The NCO and the loader both import this package, so the word layout is defined once.
package nco_word_loader_pkg;

   localparam int NCO_WORD_WIDTH  = 27;
   localparam int NCO_WAVESEL_BIT = 26;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_LATCH   = 2'd2
   } loader_state_t;

endpackage

// File: rtl/nco_word_loader_timeout_counter.sv
// Idle-cycle counter for the byte loader.
// Counts consecutive enabled cycles and saturates at TIMEOUT_CYCLES.
// 'expired' is high during the enabled cycle that completes the timeout window,
// so the owner can act on the same clock edge.
module nco_word_loader_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Idle counter: cleared on demand, saturating increment while enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = enable && !clear && (count >= LAST);

endmodule

// File: rtl/nco_word_loader.sv
// Assembles MSB-first control bytes into the NCO control word and
// pulses the NCO latch write enable once a full frame has arrived.
//
// Handshake: i_byte is taken on any cycle with i_byte_valid=1 (no backpressure);
// i_frame_start qualifies that byte as byte 0 of a frame. o_word is stable
// whenever o_latch_write_enable is high and holds its value between frames.
module nco_word_loader
   import nco_word_loader_pkg::*;
#(
   parameter int WORD_WIDTH         = NCO_WORD_WIDTH,
   parameter int BYTES_PER_WORD     = 4,
   parameter int LATCH_PULSE_CYCLES = 2,
   parameter int TIMEOUT_CYCLES     = 1024
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [7:0]            i_byte,
   input  logic                  i_byte_valid,
   input  logic                  i_frame_start,
   output logic [WORD_WIDTH-1:0] o_word,
   output logic                  o_latch_write_enable,
   output logic                  o_busy,
   output logic                  o_frame_error,
   output loader_state_t         dbg_state
);

   localparam int SW      = 8 * BYTES_PER_WORD;
   localparam int CNT_W   = $clog2(BYTES_PER_WORD + 1);
   localparam int PULSE_W = $clog2(LATCH_PULSE_CYCLES + 1);
   localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(BYTES_PER_WORD);
   localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(LATCH_PULSE_CYCLES - 1);

   loader_state_t      state, state_d;
   logic [SW-1:0]      shift_reg, shift_d;
   logic [CNT_W-1:0]   byte_cnt, cnt_d;
   logic [PULSE_W-1:0] pulse_cnt, pulse_d;
   logic               err_d;
   logic               load_word;
   logic               to_clear, to_enable, to_expired;

   // Idle time only accumulates while collecting and no byte arrives.
   assign to_clear  = (state != ST_COLLECT) || i_byte_valid;
   assign to_enable = (state == ST_COLLECT) && !i_byte_valid;

   nco_word_loader_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (i_clock),
      .rst_n  (i_reset),
      .clear  (to_clear),
      .enable (to_enable),
      .expired(to_expired)
   );

   // Next-state, datapath and error decode for the loader FSM.
   always_comb begin
      state_d   = state;
      shift_d   = shift_reg;
      cnt_d     = byte_cnt;
      pulse_d   = pulse_cnt;
      err_d     = 1'b0;
      load_word = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_byte_valid) begin
               if (i_frame_start) begin
                  shift_d = SW'(i_byte);
                  cnt_d   = CNT_W'(1);
                  state_d = (cnt_d == CNT_FULL) ? ST_LATCH : ST_COLLECT;
               end else begin
                  err_d = 1'b1;  // orphan byte
               end
            end
         end
         ST_COLLECT: begin
            if (i_byte_valid) begin
               if (i_frame_start) begin
                  // A new start simply restarts the frame; not an error.
                  shift_d = SW'(i_byte);
                  cnt_d   = CNT_W'(1);
               end else begin
                  shift_d = (shift_reg << 8) | SW'(i_byte);
                  cnt_d   = (byte_cnt == CNT_FULL) ? byte_cnt : byte_cnt + CNT_W'(1);
               end
               if (cnt_d == CNT_FULL) begin
                  state_d = ST_LATCH;
               end
            end else if (to_expired) begin
               err_d   = 1'b1;  // timeout, partial frame discarded
               state_d = ST_IDLE;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         ST_LATCH: begin
            if (i_byte_valid) begin
               err_d = 1'b1;  // overrun while latching
            end
            if (pulse_cnt == PULSE_LAST) begin
               state_d = ST_IDLE;
               pulse_d = '0;
               cnt_d   = '0;
            end else begin
               pulse_d = pulse_cnt + PULSE_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if ((state != ST_LATCH) && (state_d == ST_LATCH)) begin
         pulse_d   = '0;
         load_word = 1'b1;
      end
   end

   // State, datapath and registered outputs; o_word only moves on LATCH entry.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state                <= ST_IDLE;
         shift_reg            <= '0;
         byte_cnt             <= '0;
         pulse_cnt            <= '0;
         o_word               <= '0;
         o_latch_write_enable <= 1'b0;
         o_busy               <= 1'b0;
         o_frame_error        <= 1'b0;
      end else begin
         state                <= state_d;
         shift_reg            <= shift_d;
         byte_cnt             <= cnt_d;
         pulse_cnt            <= pulse_d;
         o_latch_write_enable <= (state_d == ST_LATCH);
         o_busy               <= (state_d != ST_IDLE);
         o_frame_error        <= err_d;
         if (load_word) begin
            o_word <= shift_d[WORD_WIDTH-1:0];
         end
      end
   end

   assign dbg_state = state;

endmodule
